// File: rtl/pl_fetch_queue_pkg.sv
// rtl/pl_fetch_queue_pkg.sv - shared constants and fetch-entry type for the fetch queue
package pl_fetch_queue_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            filled;
  } fetch_entry_t;

endpackage

// File: rtl/pl_fetch_queue_if.sv
// rtl/pl_fetch_queue_if.sv - instruction-memory and IF/ID handshake bundle
interface pl_fetch_queue_if #(
  parameter int XLEN = 32
);

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            dout_valid;
  logic [XLEN-1:0] dout_pc;
  logic [XLEN-1:0] dout_inst;
  logic            dout_ready;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output dout_valid, dout_pc, dout_inst,
    input  dout_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  dout_valid, dout_pc, dout_inst,
    output dout_ready
  );

endinterface

// File: rtl/pl_fetch_entry_ram.sv
// rtl/pl_fetch_entry_ram.sv - fetch-entry register array with alloc, fill, pop and head-read ports
module pl_fetch_entry_ram
  import pl_fetch_queue_pkg::fetch_entry_t;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic            clear_all,
  input  logic            alloc_we,
  input  logic [AW-1:0]   alloc_idx,
  input  logic [XLEN-1:0] alloc_pc,
  input  logic            fill_we,
  input  logic [AW-1:0]   fill_idx,
  input  logic [XLEN-1:0] fill_inst,
  input  logic            pop_we,
  input  logic [AW-1:0]   pop_idx,
  input  logic [AW-1:0]   head_idx,
  output fetch_entry_t    head
);

  fetch_entry_t mem [DEPTH];

  // alloc, fill and pop never target the same entry in one cycle, so their order is free
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (clear_all) begin
          mem[i].filled <= 1'b0;
        end else begin
          if (alloc_we && alloc_idx == AW'(i)) begin
            mem[i].pc     <= alloc_pc;
            mem[i].filled <= 1'b0;
          end
          if (fill_we && fill_idx == AW'(i)) begin
            mem[i].inst   <= fill_inst;
            mem[i].filled <= 1'b1;
          end
          if (pop_we && pop_idx == AW'(i)) mem[i].filled <= 1'b0;
        end
      end
    end
  end

  assign head = mem[head_idx];

endmodule

// File: rtl/pl_fetch_queue.sv
// rtl/pl_fetch_queue.sv - in-order instruction fetch queue with credit, PC stall and flush discard
module pl_fetch_queue
  import pl_fetch_queue_pkg::fetch_entry_t;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic [XLEN-1:0] pc,
  output logic            wpc,
  input  logic            flush,
  pl_fetch_queue_if.master bus
);

  logic [AW-1:0] alloc_ptr, fill_ptr, head_ptr;
  logic [AW:0]   alloc_cnt, unfill_cnt, discard_cnt;
  logic [AW+1:0] credit_sum;
  logic          alloc, fill, drop, pop;
  fetch_entry_t  head;

  // credit counts only registered state; a pop frees its slot one cycle later
  assign credit_sum   = {1'b0, alloc_cnt} + {1'b0, discard_cnt};
  assign bus.imem_req = clrn & ~flush & (credit_sum < (AW+2)'(DEPTH));
  assign bus.imem_addr = pc;
  assign alloc = bus.imem_req & bus.imem_gnt;
  assign wpc   = clrn & (alloc | flush);

  assign drop = bus.imem_rvalid & (discard_cnt != '0);
  assign fill = bus.imem_rvalid & (discard_cnt == '0) & (unfill_cnt != '0);
  assign pop  = head.filled & bus.dout_ready;

  assign bus.dout_valid = head.filled;
  assign bus.dout_pc    = head.pc;
  assign bus.dout_inst  = head.inst;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      alloc_ptr   <= '0;
      fill_ptr    <= '0;
      head_ptr    <= '0;
      alloc_cnt   <= '0;
      unfill_cnt  <= '0;
      discard_cnt <= '0;
    end else if (flush) begin
      // every unfilled entry becomes a response to drop, less one arriving right now
      alloc_ptr   <= '0;
      fill_ptr    <= '0;
      head_ptr    <= '0;
      alloc_cnt   <= '0;
      unfill_cnt  <= '0;
      discard_cnt <= discard_cnt + unfill_cnt - (AW+1)'(drop | fill);
    end else begin
      if (alloc) alloc_ptr <= alloc_ptr + 1'b1;
      if (fill)  fill_ptr  <= fill_ptr + 1'b1;
      if (pop)   head_ptr  <= head_ptr + 1'b1;
      if (drop)  discard_cnt <= discard_cnt - 1'b1;
      alloc_cnt  <= alloc_cnt + (AW+1)'(alloc) - (AW+1)'(pop);
      unfill_cnt <= unfill_cnt + (AW+1)'(alloc) - (AW+1)'(fill);
    end
  end

  pl_fetch_entry_ram #(.DEPTH(DEPTH), .AW(AW), .XLEN(XLEN)) u_ram (
    .clk       (clk),
    .clrn      (clrn),
    .clear_all (flush),
    .alloc_we  (alloc),
    .alloc_idx (alloc_ptr),
    .alloc_pc  (pc),
    .fill_we   (fill & ~flush),
    .fill_idx  (fill_ptr),
    .fill_inst (bus.imem_rdata),
    .pop_we    (pop & ~flush),
    .pop_idx   (head_ptr),
    .head_idx  (head_ptr),
    .head      (head)
  );

  // a response with nothing to drop and nothing waiting for it is a memory protocol error
  a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (!clrn)
    !(bus.imem_rvalid && discard_cnt == '0 && unfill_cnt == '0));

endmodule

// File: tb/tb_pl_fetch_queue.sv
// tb/tb_pl_fetch_queue.sv - directed self-checking bench for pl_fetch_queue
module tb_pl_fetch_queue;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        flush = 1'b0;
  logic        wpc;
  logic [31:0] pc = '0;
  logic [31:0] q [$];
  logic        s_wpc, s_req, s_dv;
  logic [31:0] s_dpc, s_dinst, s_addr;
  int          checks = 0;
  int          errors = 0;

  pl_fetch_queue_if #(.XLEN(32)) bus ();

  pl_fetch_queue #(.DEPTH(4), .AW(2), .XLEN(32)) dut (
    .clk   (clk),
    .clrn  (clrn),
    .pc    (pc),
    .wpc   (wpc),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  // one clock of environment: drive at negedge, sample, then update PC register and memory model
  task automatic cyc(input logic g, input logic rv_en, input logic fl, input logic [31:0] t, input logic rdy);
    bus.imem_gnt   = g;
    bus.dout_ready = rdy;
    flush          = fl;
    if (rv_en && q.size() > 0) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = memf(q.pop_front());
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;
    end
    #1;
    s_wpc = wpc; s_req = bus.imem_req; s_dv = bus.dout_valid;
    s_dpc = bus.dout_pc; s_dinst = bus.dout_inst; s_addr = bus.imem_addr;
    @(posedge clk); #1;
    if (s_req && g) q.push_back(s_addr);
    if (s_wpc) pc = fl ? t : pc + 32'd4;
    @(negedge clk);
  endtask

  task automatic do_reset();
    clrn = 1'b0; flush = 1'b0; pc = '0; q.delete();
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0; bus.dout_ready = 1'b0;
    repeat (2) @(negedge clk);
    clrn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    clrn = 1'b0; bus.imem_gnt = 1'b1; #1;
    checks++; if (wpc !== 1'b0) begin errors++; $display("FAIL reset_wpc got %b want 0", wpc); end
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", bus.imem_req); end
    checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL reset_dv got %b want 0", bus.dout_valid); end
    checks++; if (bus.dout_pc !== 32'h0 || bus.dout_inst !== 32'h0) begin errors++; $display("FAIL reset_dout got %h/%h want 0/0", bus.dout_pc, bus.dout_inst); end
    checks++; if (dut.alloc_cnt !== 3'd0 || dut.discard_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt got %0d/%0d want 0/0", dut.alloc_cnt, dut.discard_cnt); end
    do_reset();
  endtask

  task automatic test_stream();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      checks++; if (s_wpc !== 1'b1) begin errors++; $display("FAIL stream_wpc k=%0d got %b want 1", k, s_wpc); end
      checks++;
      if (k < 2) begin
        if (s_dv !== 1'b0) begin errors++; $display("FAIL stream_early_dv k=%0d got %b want 0", k, s_dv); end
      end else if (s_dv !== 1'b1 || s_dpc !== 32'((k-2)*4) || s_dinst !== memf(32'((k-2)*4))) begin
        errors++; $display("FAIL stream_head k=%0d got %b/%h/%h want 1/%h/%h", k, s_dv, s_dpc, s_dinst, 32'((k-2)*4), memf(32'((k-2)*4)));
      end
    end
  endtask

  task automatic test_stall();
    int grants = 0;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      if (s_req) grants++;
    end
    checks++; if (grants != 4) begin errors++; $display("FAIL stall_grants got %0d want 4", grants); end
    checks++; if (s_req !== 1'b0 || s_wpc !== 1'b0) begin errors++; $display("FAIL stall_full got req=%b wpc=%b want 0/0", s_req, s_wpc); end
    checks++; if (pc !== 32'h10) begin errors++; $display("FAIL stall_pc got %h want 00000010", pc); end
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      checks++; if (s_dv !== 1'b1 || s_dpc !== 32'(k*4)) begin errors++; $display("FAIL stall_pop k=%0d got %b/%h want 1/%h", k, s_dv, s_dpc, 32'(k*4)); end
      if (k < 2) begin
        checks++; if (s_req !== (k == 1)) begin errors++; $display("FAIL stall_credit k=%0d got %b want %b", k, s_req, k == 1); end
      end
    end
    checks++; if (pc !== 32'h1C) begin errors++; $display("FAIL stall_resume_pc got %h want 0000001c", pc); end
  endtask

  task automatic test_gnt_gap();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      checks++; if (s_wpc !== 1'b0 || s_req !== 1'b1 || pc !== 32'h0) begin errors++; $display("FAIL gap_hold k=%0d got wpc=%b req=%b pc=%h want 0/1/0", k, s_wpc, s_req, pc); end
    end
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checks++; if (s_wpc !== 1'b1) begin errors++; $display("FAIL gap_gnt_wpc got %b want 1", s_wpc); end
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checks++; if (s_wpc !== 1'b0 || pc !== 32'h4) begin errors++; $display("FAIL gap_after got wpc=%b pc=%h want 0/4", s_wpc, pc); end
  endtask

  task automatic test_flush_discard();
    int first = -1;
    do_reset();
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 32'h100, 1'b1);
    checks++; if (s_req !== 1'b0 || s_wpc !== 1'b1) begin errors++; $display("FAIL fd_flush got req=%b wpc=%b want 0/1", s_req, s_wpc); end
    checks++; if (dut.discard_cnt !== 3'd3 || pc !== 32'h100) begin errors++; $display("FAIL fd_discard got %0d pc=%h want 3 pc=100", dut.discard_cnt, pc); end
    for (int k = 0; k < 12 && first < 0; k++) begin
      cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      if (s_dv) begin
        first = k;
        checks++; if (s_dpc !== 32'h100 || s_dinst !== memf(32'h100)) begin errors++; $display("FAIL fd_first got %h/%h want 00000100/%h", s_dpc, s_dinst, memf(32'h100)); end
      end
    end
    checks++; if (first != 4) begin errors++; $display("FAIL fd_latency got %0d want 4", first); end
    checks++; if (dut.discard_cnt !== 3'd0) begin errors++; $display("FAIL fd_drained got %0d want 0", dut.discard_cnt); end
  endtask

  task automatic test_flush_rvalid();
    int first = -1;
    int stale = 0;
    do_reset();
    repeat (2) cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 32'h200, 1'b1);
    checks++; if (s_wpc !== 1'b1 || s_req !== 1'b0) begin errors++; $display("FAIL fr_flush got wpc=%b req=%b want 1/0", s_wpc, s_req); end
    checks++; if (dut.discard_cnt !== 3'd1) begin errors++; $display("FAIL fr_discard got %0d want 1", dut.discard_cnt); end
    for (int k = 0; k < 10; k++) begin
      cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      if (s_dv && s_dpc < 32'h200) stale++;
      if (s_dv && first < 0) begin
        first = k;
        checks++; if (s_dpc !== 32'h200 || s_dinst !== memf(32'h200)) begin errors++; $display("FAIL fr_first got %h/%h want 00000200/%h", s_dpc, s_dinst, memf(32'h200)); end
      end
    end
    checks++; if (first != 2) begin errors++; $display("FAIL fr_latency got %0d want 2", first); end
    checks++; if (stale != 0) begin errors++; $display("FAIL fr_stale got %0d want 0", stale); end
  endtask

  task automatic test_async_reset();
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    bus.imem_gnt = 1'b1; bus.imem_rvalid = 1'b0; bus.dout_ready = 1'b0; #1;
    checks++; if (bus.dout_valid !== 1'b1 || bus.dout_pc !== 32'h4 || wpc !== 1'b1) begin errors++; $display("FAIL ar_pre got dv=%b pc=%h wpc=%b want 1/4/1", bus.dout_valid, bus.dout_pc, wpc); end
    #1 clrn = 1'b0; #1;
    checks++; if (wpc !== 1'b0 || bus.imem_req !== 1'b0 || bus.dout_valid !== 1'b0) begin errors++; $display("FAIL ar_ctl got wpc=%b req=%b dv=%b want 0/0/0", wpc, bus.imem_req, bus.dout_valid); end
    checks++; if (bus.dout_pc !== 32'h0 || bus.dout_inst !== 32'h0) begin errors++; $display("FAIL ar_dout got %h/%h want 0/0", bus.dout_pc, bus.dout_inst); end
    do_reset();
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      if (k >= 2) begin
        checks++; if (s_dv !== 1'b1 || s_dpc !== 32'((k-2)*4) || s_dinst !== memf(32'((k-2)*4))) begin errors++; $display("FAIL ar_restart k=%0d got %b/%h/%h want 1/%h", k, s_dv, s_dpc, s_dinst, 32'((k-2)*4)); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_gnt_gap();
    test_flush_discard();
    test_flush_rvalid();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
